next_pc_unit: RTL and testbench

Program-counter stage of the multi-cycle RV32I core, directly downstream of the branch comparator. It holds the architectural PC and consumes the comparator's one-bit `flag` together with the decoded control-flow kind, immediate and rs1. On each advance strobe from the control FSM it commits the next PC: sequential, branch, JAL or JALR. It also detects misaligned jump/branch targets, freezes into a trap state on one, and counts retired instructions.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/pc_target_calc.sv | 39 +++
 rtl/next_pc_unit.sv | 109 ++++++++++
 tb/tb_next_pc_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV32I multi-cycle core: PC control-flow
// kinds, PC-stage FSM states and the branch comparator's funct3 encodings.
package cpu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JAL    = 2'd2,
        PC_JALR   = 2'd3
    } pc_kind_t;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } pc_state_t;

    // Branch comparator funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC target, taken decision and alignment check.
module pc_target_calc
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic [1:0]      pc_kind,
    input  logic            flag,
    output logic [XLEN-1:0] target,
    output logic            taken,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    logic [XLEN-1:0] pc_rel;
    logic [XLEN-1:0] reg_rel;

    assign pc_rel  = pc + imm;
    assign reg_rel = (rs1 + imm) & JALR_MASK;

    // Select target and taken by control-flow kind; a not-taken target never faults
    always_comb begin
        target = pc_rel;
        taken  = 1'b0;
        case (pc_kind_t'(pc_kind))
            PC_SEQ:    begin target = pc_rel;  taken = 1'b0; end
            PC_BRANCH: begin target = pc_rel;  taken = flag; end
            PC_JAL:    begin target = pc_rel;  taken = 1'b1; end
            PC_JALR:   begin target = reg_rel; taken = 1'b1; end
            default:   begin target = pc_rel;  taken = 1'b0; end
        endcase
        misaligned = taken && (target[1:0] != 2'b00);
    end

endmodule

// File: rtl/next_pc_unit.sv
// Program-counter stage: commits the next PC on each advance strobe, traps on
// misaligned taken targets and counts retired instructions.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   RUN   | normal operation; advance commits one instruction
//   TRAP  | misaligned taken target seen; absorbing until reset
module next_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            advance,
    input  logic [1:0]      pc_kind,
    input  logic            flag,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            redirect,
    output logic            trap,
    output logic [XLEN-1:0] trap_pc,
    output logic [31:0]     instret
);

    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] trap_pc_q, trap_pc_d;
    logic [31:0]     instret_q, instret_d;
    logic            redirect_q, redirect_d;

    logic [XLEN-1:0] target;
    logic            taken;
    logic            misaligned;

    pc_target_calc #(.XLEN(XLEN)) u_calc (
        .pc         (pc_q),
        .imm        (imm),
        .rs1        (rs1),
        .pc_kind    (pc_kind),
        .flag       (flag),
        .target     (target),
        .taken      (taken),
        .misaligned (misaligned)
    );

    assign pc_plus4 = pc_q + FOUR;

    // Next-state and next-register values; registers hold unless a RUN commit happens
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        trap_pc_d  = trap_pc_q;
        instret_d  = instret_q;
        redirect_d = 1'b0;
        case (state_q)
            RUN: begin
                if (advance) begin
                    if (misaligned) begin
                        state_d   = TRAP;
                        trap_pc_d = pc_q;
                    end else if (taken) begin
                        pc_d       = target;
                        redirect_d = 1'b1;
                        instret_d  = instret_q + 32'd1;
                    end else begin
                        pc_d      = pc_plus4;
                        instret_d = instret_q + 32'd1;
                    end
                end
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State and architectural registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC[XLEN-1:0];
            trap_pc_q  <= '0;
            instret_q  <= '0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            trap_pc_q  <= trap_pc_d;
            instret_q  <= instret_d;
            redirect_q <= redirect_d;
        end
    end

    assign pc       = pc_q;
    assign trap     = (state_q == TRAP);
    assign trap_pc  = trap_pc_q;
    assign instret  = instret_q;
    assign redirect = redirect_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed self-checking bench for next_pc_unit.
module tb_next_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        advance;
    logic [1:0]  pc_kind;
    logic        flag;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic        trap;
    logic [31:0] trap_pc;
    logic [31:0] instret;

    int n_checks = 0;
    int n_fail   = 0;

    next_pc_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance  (advance),
        .pc_kind  (pc_kind),
        .flag     (flag),
        .imm      (imm),
        .rs1      (rs1),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .redirect (redirect),
        .trap     (trap),
        .trap_pc  (trap_pc),
        .instret  (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, then sample 1 time unit after the edge
    task automatic cyc(input logic adv, input logic [1:0] kind, input logic f,
                       input logic [31:0] im, input logic [31:0] r1);
        advance = adv; pc_kind = kind; flag = f; imm = im; rs1 = r1;
        @(posedge clk);
        #1;
        advance = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        cyc(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc actual=%h required=%h", pc, 32'h0); end
        n_checks++; if (pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL reset_pc_plus4 actual=%h required=%h", pc_plus4, 32'h4); end
        n_checks++; if (trap !== 1'b0) begin n_fail++; $display("FAIL reset_trap actual=%b required=0", trap); end
        n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL reset_redirect actual=%b required=0", redirect); end
        n_checks++; if (instret !== 32'h0) begin n_fail++; $display("FAIL reset_instret actual=%0d required=0", instret); end
        n_checks++; if (trap_pc !== 32'h0) begin n_fail++; $display("FAIL reset_trap_pc actual=%h required=0", trap_pc); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 2'd0, 1'b0, 32'h0, 32'h0);
            n_checks++; if (pc !== exp_pc[i]) begin n_fail++; $display("FAIL seq_pc[%0d] actual=%h required=%h", i, pc, exp_pc[i]); end
            n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL seq_redirect[%0d] actual=%b required=0", i, redirect); end
        end
        n_checks++; if (instret !== 32'd3) begin n_fail++; $display("FAIL seq_instret actual=%0d required=3", instret); end
    endtask

    task automatic test_branch();
        // 0xC -> 0x10
        cyc(1'b1, 2'd0, 1'b0, 32'h0, 32'h0);
        n_checks++; if (pc !== 32'h10) begin n_fail++; $display("FAIL br_setup_pc actual=%h required=10", pc); end
        // taken branch imm=-8
        cyc(1'b1, 2'd1, 1'b1, 32'hFFFF_FFF8, 32'h0);
        n_checks++; if (pc !== 32'h8) begin n_fail++; $display("FAIL br_taken_pc actual=%h required=8", pc); end
        n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL br_taken_redirect actual=%b required=1", redirect); end
        n_checks++; if (instret !== 32'd5) begin n_fail++; $display("FAIL br_taken_instret actual=%0d required=5", instret); end
        cyc(1'b0, 2'd1, 1'b1, 32'hFFFF_FFF8, 32'h0);
        n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL br_redirect_pulse actual=%b required=0", redirect); end
        n_checks++; if (pc !== 32'h8) begin n_fail++; $display("FAIL idle_hold_pc actual=%h required=8", pc); end
        // JAL +8 back to 0x10
        cyc(1'b1, 2'd2, 1'b0, 32'h8, 32'h0);
        n_checks++; if (pc !== 32'h10) begin n_fail++; $display("FAIL jal_pc actual=%h required=10", pc); end
        n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL jal_redirect actual=%b required=1", redirect); end
        // not-taken branch imm=-8
        cyc(1'b1, 2'd1, 1'b0, 32'hFFFF_FFF8, 32'h0);
        n_checks++; if (pc !== 32'h14) begin n_fail++; $display("FAIL br_nt_pc actual=%h required=14", pc); end
        n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL br_nt_redirect actual=%b required=0", redirect); end
        n_checks++; if (instret !== 32'd7) begin n_fail++; $display("FAIL br_nt_instret actual=%0d required=7", instret); end
        // not-taken branch with misaligned target does not trap
        cyc(1'b1, 2'd1, 1'b0, 32'h6, 32'h0);
        n_checks++; if (pc !== 32'h18) begin n_fail++; $display("FAIL br_nt_mis_pc actual=%h required=18", pc); end
        n_checks++; if (trap !== 1'b0) begin n_fail++; $display("FAIL br_nt_mis_trap actual=%b required=0", trap); end
    endtask

    task automatic test_wrap();
        cyc(1'b1, 2'd3, 1'b0, 32'hC, 32'hFFFF_FFF0);
        n_checks++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_jalr_pc actual=%h required=fffffffc", pc); end
        n_checks++; if (pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc_plus4 actual=%h required=0", pc_plus4); end
        cyc(1'b1, 2'd0, 1'b0, 32'h0, 32'h0);
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_seq_pc actual=%h required=0", pc); end
        n_checks++; if (trap !== 1'b0) begin n_fail++; $display("FAIL wrap_trap actual=%b required=0", trap); end
        n_checks++; if (instret !== 32'd10) begin n_fail++; $display("FAIL wrap_instret actual=%0d required=10", instret); end
    endtask

    task automatic test_jalr_trap();
        cyc(1'b1, 2'd0, 1'b0, 32'h0, 32'h0);
        // rs1=0x101 + 2 = 0x103, bit0 cleared -> 0x102: misaligned
        cyc(1'b1, 2'd3, 1'b0, 32'h2, 32'h101);
        n_checks++; if (trap !== 1'b1) begin n_fail++; $display("FAIL jalr_trap actual=%b required=1", trap); end
        n_checks++; if (trap_pc !== 32'h4) begin n_fail++; $display("FAIL jalr_trap_pc actual=%h required=4", trap_pc); end
        n_checks++; if (pc !== 32'h4) begin n_fail++; $display("FAIL jalr_trap_pc_hold actual=%h required=4", pc); end
        n_checks++; if (instret !== 32'd11) begin n_fail++; $display("FAIL jalr_trap_instret actual=%0d required=11", instret); end
        n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL jalr_trap_redirect actual=%b required=0", redirect); end
        cyc(1'b1, 2'd0, 1'b0, 32'h0, 32'h0);
        cyc(1'b1, 2'd2, 1'b0, 32'h40, 32'h0);
        n_checks++; if (pc !== 32'h4) begin n_fail++; $display("FAIL trap_ignore_pc actual=%h required=4", pc); end
        n_checks++; if (instret !== 32'd11) begin n_fail++; $display("FAIL trap_ignore_instret actual=%0d required=11", instret); end
        n_checks++; if (trap !== 1'b1) begin n_fail++; $display("FAIL trap_sticky actual=%b required=1", trap); end
        n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL trap_ignore_redirect actual=%b required=0", redirect); end
        do_reset();
        n_checks++; if (trap !== 1'b0) begin n_fail++; $display("FAIL reset_from_trap actual=%b required=0", trap); end
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_from_trap_pc actual=%h required=0", pc); end
    endtask

    task automatic test_branch_trap();
        cyc(1'b1, 2'd0, 1'b0, 32'h0, 32'h0);
        cyc(1'b1, 2'd1, 1'b1, 32'h6, 32'h0);
        n_checks++; if (trap !== 1'b1) begin n_fail++; $display("FAIL br_mis_trap actual=%b required=1", trap); end
        n_checks++; if (trap_pc !== 32'h4) begin n_fail++; $display("FAIL br_mis_trap_pc actual=%h required=4", trap_pc); end
        n_checks++; if (instret !== 32'd1) begin n_fail++; $display("FAIL br_mis_instret actual=%0d required=1", instret); end
        do_reset();
    endtask

    task automatic test_reset_priority();
        cyc(1'b1, 2'd0, 1'b0, 32'h0, 32'h0);
        cyc(1'b1, 2'd0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        cyc(1'b1, 2'd2, 1'b0, 32'h100, 32'h0);
        rst_n = 1'b1;
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rstprio_pc actual=%h required=0", pc); end
        n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL rstprio_redirect actual=%b required=0", redirect); end
        n_checks++; if (instret !== 32'd0) begin n_fail++; $display("FAIL rstprio_instret actual=%0d required=0", instret); end
    endtask

    initial begin
        rst_n = 1'b0; advance = 1'b0; pc_kind = 2'd0; flag = 1'b0; imm = '0; rs1 = '0;
        test_reset();
        test_sequential();
        test_branch();
        test_wrap();
        test_jalr_trap();
        test_branch_trap();
        test_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
